// File: rtl/note_decoder.sv
// note_decoder: recognises which piano tone (C4..C5) is present on an
// asynchronous square-wave input by measuring the period between rising
// edges. A note must be seen on two consecutive periods before it is driven.
// Optional 7-segment letter display: define NOTE_DECODER_SEG_EN.
// The nominal periods are parameters so a scaled-down instance can be built;
// the defaults are the real 100 MHz tone periods.
module note_decoder #(
  parameter int TOL     = 4000,
  parameter int TIMEOUT = 1000000,
  parameter int P_C4    = 382219,
  parameter int P_D4    = 340530,
  parameter int P_E4    = 303370,
  parameter int P_F4    = 286344,
  parameter int P_G4    = 255102,
  parameter int P_A4    = 227273,
  parameter int P_B4    = 202478,
  parameter int P_C5    = 191113
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       FREQ,
  output logic [7:0] note,
  output logic       note_valid,
  output logic       note_stb,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam logic [19:0] TOL_W     = 20'(TOL);
  localparam logic [19:0] TIMEOUT_W = 20'(TIMEOUT);
  // Packed so that slice gi lines up with note bit gi ([7]=C4 .. [0]=C5).
  localparam logic [8*20-1:0] NOM = {20'(P_C4), 20'(P_D4), 20'(P_E4), 20'(P_F4),
                                     20'(P_G4), 20'(P_A4), 20'(P_B4), 20'(P_C5)};

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_CONFIRM, S_LOCKED} state_t;

  logic        r_sync1, r_sync2, r_sync3, r_edge;
  logic [19:0] r_cnt;
  state_t      r_state;
  logic [7:0]  r_cand;
  logic [7:0]  r_note;
  logic        r_valid;
  logic        r_stb;

  logic [7:0]  w_match;
  logic [7:0]  w_class;
  logic        w_timeout;

  // Two-flop synchronizer, one extra stage for edge history, then a
  // registered rising-edge pulse so the FSM sees the edge 3 cycles after the pin.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= FREQ;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  // Period counter: restarts at 1 on each edge so it holds the full period
  // at the next edge; parked at 0 while idle; saturates at TIMEOUT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
    end else if (r_edge) begin
      r_cnt <= 20'd1;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_cnt < TIMEOUT_W) begin
      r_cnt <= r_cnt + 20'd1;
    end
  end

  assign w_timeout = (r_state != S_IDLE) && (r_cnt == TIMEOUT_W);

  // One tolerance window comparator per note.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_win
      localparam logic [19:0] NOM_G = NOM[gi*20 +: 20];
      logic [19:0] w_diff;
      assign w_diff      = (r_cnt >= NOM_G) ? (r_cnt - NOM_G) : (NOM_G - r_cnt);
      assign w_match[gi] = (w_diff <= TOL_W);
    end
  endgenerate

  // Keep only the lowest matching bit so the class stays one-hot even if a
  // wide TOL makes windows overlap; all-zero means NONE.
  assign w_class = w_match & (~w_match + 8'd1);

  // Confirmation FSM with registered note outputs; an edge takes priority
  // over a simultaneous timeout (it then carries a TIMEOUT-long NONE period).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_note  <= '0;
      r_valid <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (r_edge) begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_MEASURE;
          end
          S_MEASURE: begin
            r_state <= S_CONFIRM;
            r_cand  <= w_class;
          end
          S_CONFIRM: begin
            if (w_class == r_cand) begin
              r_state <= S_LOCKED;
              r_note  <= r_cand;
              r_valid <= |r_cand;
              r_stb   <= (r_cand != r_note);
            end else begin
              r_cand <= w_class;
            end
          end
          S_LOCKED: begin
            if (w_class != r_note) begin
              r_state <= S_CONFIRM;
              r_cand  <= w_class;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end else if (w_timeout) begin
        r_state <= S_IDLE;
        r_cand  <= '0;
        r_note  <= '0;
        r_valid <= 1'b0;
        r_stb   <= |r_note;
      end
    end
  end

  assign note       = r_note;
  assign note_valid = r_valid;
  assign note_stb   = r_stb;

`ifdef NOTE_DECODER_SEG_EN
  logic [3:0] r_an;
  logic [7:0] w_seg;

  // Single digit enabled once out of reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_an <= 4'hF;
    end else begin
      r_an <= 4'b1110;
    end
  end

  // Letter of the driven note, active-low {dp,g,f,e,d,c,b,a}.
  always_comb begin
    w_seg = 8'hFF;
    case (r_note)
      8'h80:   w_seg = 8'hC6;
      8'h40:   w_seg = 8'hA1;
      8'h20:   w_seg = 8'h86;
      8'h10:   w_seg = 8'h8E;
      8'h08:   w_seg = 8'hC2;
      8'h04:   w_seg = 8'h88;
      8'h02:   w_seg = 8'h83;
      8'h01:   w_seg = 8'hC6;
      default: w_seg = 8'hFF;
    endcase
  end

  assign seg = w_seg;
  assign an  = r_an;
`else
  assign seg = 8'hFF;
  assign an  = 4'hF;
`endif

endmodule

// File: tb/tb_note_decoder.sv
// Directed bench for note_decoder. The decoder is built with periods scaled
// down by 1000 (TOL 4, TIMEOUT 1000) so every scenario runs in a few
// thousand cycles; windows stay disjoint at this scale.
module tb_note_decoder;

  localparam int TOL  = 4;
  localparam int TO   = 1000;
  localparam int PC4  = 382;
  localparam int PD4  = 341;
  localparam int PE4  = 303;
  localparam int PF4  = 286;
  localparam int PG4  = 255;
  localparam int PA4  = 227;
  localparam int PB4  = 202;
  localparam int PC5  = 191;
  localparam int PNON = 270;

`ifdef NOTE_DECODER_SEG_EN
  localparam logic [3:0] AN_ON  = 4'b1110;
  localparam logic [7:0] SEG_C  = 8'hC6;
  localparam logic [7:0] SEG_G  = 8'hC2;
`else
  localparam logic [3:0] AN_ON  = 4'hF;
  localparam logic [7:0] SEG_C  = 8'hFF;
  localparam logic [7:0] SEG_G  = 8'hFF;
`endif

  logic       clk;
  logic       rst_n;
  logic       freq;
  logic [7:0] note;
  logic       note_valid;
  logic       note_stb;
  logic [7:0] seg;
  logic [3:0] an;

  int n_vec;
  int n_err;
  int since;

  note_decoder #(
    .TOL(TOL), .TIMEOUT(TO),
    .P_C4(PC4), .P_D4(PD4), .P_E4(PE4), .P_F4(PF4),
    .P_G4(PG4), .P_A4(PA4), .P_B4(PB4), .P_C5(PC5)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .FREQ(freq),
    .note(note),
    .note_valid(note_valid),
    .note_stb(note_stb),
    .seg(seg),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clocks, leaving time 1 ns after the last rising edge.
  task automatic clks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      since++;
    end
  endtask

  // Next rising pin edge exactly p cycles after the previous one.
  task automatic rise_after(input int p);
    clks(p / 2 - since);
    freq = 1'b0;
    clks(p - since);
    freq = 1'b1;
    since = 0;
  endtask

  // Edge then wait until its registered outputs are visible.
  task automatic pulse_edge(input int p);
    rise_after(p);
    clks(4);
  endtask

  task automatic test_reset;
    logic [9:0] obs;
    rst_n = 1'b0;
    freq  = 1'b0;
    #12;
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== 10'h000 || seg !== 8'hFF || an !== 4'hF) begin
      n_err++;
      $display("FAIL reset_outputs: got note/v/stb=%h seg=%h an=%h, expected 000 FF F", obs, seg, an);
    end else $display("ok   reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    since = 0;
    clks(2);
    n_vec++;
    if (an !== AN_ON || seg !== 8'hFF || note !== 8'h00) begin
      n_err++;
      $display("FAIL post_reset: got an=%h seg=%h note=%h, expected an=%h seg=FF note=00", an, seg, note, AN_ON);
    end else $display("ok   post_reset");
  endtask

  task automatic test_lock_e4;
    logic [9:0] obs;
    freq = 1'b1;
    since = 0;
    clks(4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== 10'h000) begin
      n_err++; $display("FAIL e4_edge1: got %h expected %h", obs, 10'h000);
    end else $display("ok   e4_edge1");
    pulse_edge(PE4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== 10'h000) begin
      n_err++; $display("FAIL e4_edge2: got %h expected %h", obs, 10'h000);
    end else $display("ok   e4_edge2");
    rise_after(PE4);
    clks(3);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== 10'h000) begin
      n_err++; $display("FAIL e4_edge3_early: got %h expected %h", obs, 10'h000);
    end else $display("ok   e4_edge3_early");
    clks(1);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h20, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL e4_lock: got %h expected %h", obs, {8'h20, 1'b1, 1'b1});
    end else $display("ok   e4_lock");
    clks(1);
    n_vec++;
    if (note_stb !== 1'b0) begin
      n_err++; $display("FAIL e4_stb_width: got %b expected 0", note_stb);
    end else $display("ok   e4_stb_width");
    pulse_edge(PE4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h20, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL e4_hold: got %h expected %h", obs, {8'h20, 1'b1, 1'b0});
    end else $display("ok   e4_hold");
  endtask

  task automatic test_switch_g4;
    logic [9:0] obs;
    pulse_edge(PG4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h20, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL g4_pending: got %h expected %h", obs, {8'h20, 1'b1, 1'b0});
    end else $display("ok   g4_pending");
    pulse_edge(PG4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h08, 1'b1, 1'b1} || seg !== SEG_G) begin
      n_err++; $display("FAIL g4_lock: got %h seg=%h expected %h seg=%h", obs, seg, {8'h08, 1'b1, 1'b1}, SEG_G);
    end else $display("ok   g4_lock");
  endtask

  task automatic test_glitch_same_note;
    logic [9:0] obs;
    pulse_edge(PE4);
    pulse_edge(PG4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h08, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL glitch_held: got %h expected %h", obs, {8'h08, 1'b1, 1'b0});
    end else $display("ok   glitch_held");
    pulse_edge(PG4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h08, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reconfirm_no_stb: got %h expected %h", obs, {8'h08, 1'b1, 1'b0});
    end else $display("ok   reconfirm_no_stb");
  endtask

  task automatic test_none_clear;
    logic [9:0] obs;
    pulse_edge(PA4);
    pulse_edge(PA4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h04, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL a4_lock: got %h expected %h", obs, {8'h04, 1'b1, 1'b1});
    end else $display("ok   a4_lock");
    pulse_edge(PNON);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h04, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL none_first: got %h expected %h", obs, {8'h04, 1'b1, 1'b0});
    end else $display("ok   none_first");
    pulse_edge(PNON);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h00, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL none_clear: got %h expected %h", obs, {8'h00, 1'b0, 1'b1});
    end else $display("ok   none_clear");
  endtask

  task automatic test_tolerance;
    logic [9:0] obs;
    pulse_edge(PC4 + TOL);
    pulse_edge(PC4 - TOL);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h80, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL tol_lock_c4: got %h expected %h", obs, {8'h80, 1'b1, 1'b1});
    end else $display("ok   tol_lock_c4");
    pulse_edge(PC4 + TOL);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h80, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL tol_upper_keep: got %h expected %h", obs, {8'h80, 1'b1, 1'b0});
    end else $display("ok   tol_upper_keep");
    pulse_edge(PC4 + TOL + 1);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h80, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL tol_out_first: got %h expected %h", obs, {8'h80, 1'b1, 1'b0});
    end else $display("ok   tol_out_first");
    pulse_edge(PC4 + TOL + 1);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h00, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL tol_out_none: got %h expected %h", obs, {8'h00, 1'b0, 1'b1});
    end else $display("ok   tol_out_none");
  endtask

  task automatic test_timeout;
    logic [9:0] obs;
    pulse_edge(PC5);
    pulse_edge(PC5);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h01, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL c5_lock: got %h expected %h", obs, {8'h01, 1'b1, 1'b1});
    end else $display("ok   c5_lock");
    freq = 1'b0;
    clks(TO - 1);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h01, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL timeout_early: got %h expected %h", obs, {8'h01, 1'b1, 1'b0});
    end else $display("ok   timeout_early");
    clks(1);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h00, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL timeout_fire: got %h expected %h", obs, {8'h00, 1'b0, 1'b1});
    end else $display("ok   timeout_fire");
    clks(1);
    n_vec++;
    if (note_stb !== 1'b0) begin
      n_err++; $display("FAIL timeout_stb_width: got %b expected 0", note_stb);
    end else $display("ok   timeout_stb_width");
    // From IDLE three edges are needed again.
    freq = 1'b1;
    since = 0;
    clks(4);
    pulse_edge(PC5);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== 10'h000) begin
      n_err++; $display("FAIL idle_edge2: got %h expected %h", obs, 10'h000);
    end else $display("ok   idle_edge2");
    pulse_edge(PC5);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h01, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL idle_relock: got %h expected %h", obs, {8'h01, 1'b1, 1'b1});
    end else $display("ok   idle_relock");
  endtask

  task automatic test_reset_mid;
    logic [9:0] obs;
    pulse_edge(PC4);
    pulse_edge(PC4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h80, 1'b1, 1'b1} || seg !== SEG_C || an !== AN_ON) begin
      n_err++; $display("FAIL c4_lock: got %h seg=%h an=%h expected %h seg=%h an=%h", obs, seg, an, {8'h80, 1'b1, 1'b1}, SEG_C, AN_ON);
    end else $display("ok   c4_lock");
    freq = 1'b0;
    clks(100);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== 10'h000 || seg !== 8'hFF || an !== 4'hF) begin
      n_err++; $display("FAIL async_reset: got %h seg=%h an=%h expected 000 FF F", obs, seg, an);
    end else $display("ok   async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clks(10);
    freq = 1'b1;
    since = 0;
    clks(4);
    pulse_edge(PC4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== 10'h000) begin
      n_err++; $display("FAIL reset_edge2: got %h expected %h", obs, 10'h000);
    end else $display("ok   reset_edge2");
    pulse_edge(PC4);
    obs = {note, note_valid, note_stb};
    n_vec++;
    if (obs !== {8'h80, 1'b1, 1'b1} || seg !== SEG_C || an !== AN_ON) begin
      n_err++; $display("FAIL reset_relock: got %h seg=%h an=%h expected %h seg=%h an=%h", obs, seg, an, {8'h80, 1'b1, 1'b1}, SEG_C, AN_ON);
    end else $display("ok   reset_relock");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    since = 0;
    rst_n = 1'b0;
    freq  = 1'b0;
    test_reset();
    test_lock_e4();
    test_switch_g4();
    test_glitch_same_note();
    test_none_clear();
    test_tolerance();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
